ahb_line_fill_ctrl: RTL and testbench

AHB-Lite master that services instruction-cache line refills. It accepts a miss request from the I-cache (`mem_req`/`mem_addr`) and issues one INCR4 word burst from the line-aligned address. It assembles the four 32-bit beats into a 128-bit line and returns it with a one-cycle `mem_ready` pulse. It sits between the cache's main-memory port and the AHB bus.

---
 rtl/ahb_pkg.sv | 21 ++
 rtl/fill_line_buffer.sv | 42 ++++
 rtl/ahb_line_fill_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ahb_line_fill_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the line-fill FSM state type.
// No ports: constants and types only.
package ahb_pkg;

   localparam int unsigned WORD_W = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   typedef enum logic [1:0] {
      FILL_IDLE  = 2'b00,
      FILL_ADDR  = 2'b01,
      FILL_BURST = 2'b10,
      FILL_DONE  = 2'b11
   } fill_state_t;

endpackage

// File: rtl/fill_line_buffer.sv
// Cache-line assembly register: one 32-bit slot written per accepted beat.
// Ports: clk, rst (sync, active-high), wr_en/wr_slot/wr_data (beat write),
//        line (assembled line, beat k in bits [32k+31:32k]).
module fill_line_buffer
   import ahb_pkg::*;
#(
   parameter int unsigned LINE_BITS = 128
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  wr_en,
   input  logic [$clog2(LINE_BITS/WORD_W)-1:0]   wr_slot,
   input  logic [WORD_W-1:0]                     wr_data,
   output logic [LINE_BITS-1:0]                  line
);

   localparam int unsigned BEATS  = LINE_BITS / WORD_W;
   localparam int unsigned SLOT_W = $clog2(BEATS);

   logic [LINE_BITS-1:0] line_d, line_q;

   // Replace only the addressed slot; other slots keep their contents.
   always_comb begin
      line_d = line_q;
      for (int unsigned k = 0; k < BEATS; k++) begin
         if (wr_en && (wr_slot == SLOT_W'(k))) begin
            line_d[k*WORD_W +: WORD_W] = wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   assign line = line_q;

endmodule

// File: rtl/ahb_line_fill_ctrl.sv
// AHB-Lite read master refilling one I-cache line with a single INCR4 burst.
// Ports: clk, rst (sync, active-high); cache side mem_req/mem_addr in,
//        mem_data/mem_ready/mem_err out; AHB side haddr/htrans/hburst/hsize/
//        hwrite out, hrdata/hready/hresp in.
module ahb_line_fill_ctrl
   import ahb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned LINE_BITS = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_req,
   input  logic [ADDR_W-1:0]    mem_addr,
   output logic [LINE_BITS-1:0] mem_data,
   output logic                 mem_ready,
   output logic                 mem_err,
   output logic [ADDR_W-1:0]    haddr,
   output logic [1:0]           htrans,
   output logic [2:0]           hburst,
   output logic [2:0]           hsize,
   output logic                 hwrite,
   input  logic [WORD_W-1:0]    hrdata,
   input  logic                 hready,
   input  logic                 hresp
);

   localparam int unsigned BEATS  = LINE_BITS / WORD_W;
   localparam int unsigned OFF_W  = $clog2(LINE_BITS / 8);
   localparam int unsigned D_W    = $clog2(BEATS);
   localparam int unsigned A_W    = $clog2(BEATS + 1);
   localparam int unsigned BYTE_W = OFF_W - D_W;

   localparam logic [A_W-1:0] A_END  = A_W'(BEATS);
   localparam logic [D_W-1:0] D_LAST = D_W'(BEATS - 1);

   fill_state_t       state_d, state_q;
   logic [A_W-1:0]    acnt_d, acnt_q;
   logic [D_W-1:0]    dcnt_d, dcnt_q;
   logic              err_d, err_q;
   logic              cancel_d, cancel_q;
   logic [ADDR_W-1:0] haddr_d, haddr_q;
   logic [1:0]        htrans_d, htrans_q;
   logic              mem_ready_d, mem_ready_q;
   logic              mem_err_d, mem_err_q;
   logic              buf_we;

   // Offset-within-line bits of the miss address never matter.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^mem_addr[OFF_W-1:0];

   // Next-state, counters and registered bus/cache outputs.
   always_comb begin
      state_d     = state_q;
      acnt_d      = acnt_q;
      dcnt_d      = dcnt_q;
      err_d       = err_q;
      cancel_d    = cancel_q;
      haddr_d     = haddr_q;
      buf_we      = 1'b0;
      htrans_d    = HTRANS_IDLE;
      mem_ready_d = 1'b0;
      mem_err_d   = 1'b0;

      case (state_q)
         FILL_IDLE: begin
            if (mem_req) begin
               state_d  = FILL_ADDR;
               acnt_d   = '0;
               dcnt_d   = '0;
               err_d    = 1'b0;
               cancel_d = 1'b0;
               haddr_d  = {mem_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            end
         end
         FILL_ADDR: begin
            if (hready) begin
               state_d = FILL_BURST;
               acnt_d  = A_W'(1);
               haddr_d = {haddr_q[ADDR_W-1:OFF_W], acnt_d[D_W-1:0], BYTE_W'(0)};
            end
         end
         FILL_BURST: begin
            if (hresp) begin
               // Two-cycle ERROR: cancel on the first, finish on the second.
               cancel_d = 1'b1;
               if (hready) begin
                  err_d   = 1'b1;
                  state_d = FILL_DONE;
               end
            end else if (hready) begin
               buf_we = 1'b1;
               if (acnt_q != A_END) begin
                  acnt_d = acnt_q + A_W'(1);
                  if (acnt_d != A_END) begin
                     haddr_d = {haddr_q[ADDR_W-1:OFF_W], acnt_d[D_W-1:0], BYTE_W'(0)};
                  end
               end
               if (dcnt_q == D_LAST) begin
                  state_d = FILL_DONE;
               end else begin
                  dcnt_d = dcnt_q + D_W'(1);
               end
            end
         end
         FILL_DONE: begin
            state_d = FILL_IDLE;
         end
         default: begin
            state_d = FILL_IDLE;
         end
      endcase

      case (state_d)
         FILL_ADDR:  htrans_d = HTRANS_NONSEQ;
         FILL_BURST: htrans_d = ((acnt_d != A_END) && !cancel_d) ? HTRANS_SEQ : HTRANS_IDLE;
         default:    htrans_d = HTRANS_IDLE;
      endcase

      mem_ready_d = (state_d == FILL_DONE);
      mem_err_d   = (state_d == FILL_DONE) && err_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL_IDLE;
         acnt_q      <= '0;
         dcnt_q      <= '0;
         err_q       <= 1'b0;
         cancel_q    <= 1'b0;
         haddr_q     <= '0;
         htrans_q    <= HTRANS_IDLE;
         mem_ready_q <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acnt_q      <= acnt_d;
         dcnt_q      <= dcnt_d;
         err_q       <= err_d;
         cancel_q    <= cancel_d;
         haddr_q     <= haddr_d;
         htrans_q    <= htrans_d;
         mem_ready_q <= mem_ready_d;
         mem_err_q   <= mem_err_d;
      end
   end

   fill_line_buffer #(
      .LINE_BITS (LINE_BITS)
   ) u_line_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (buf_we),
      .wr_slot (dcnt_q),
      .wr_data (hrdata),
      .line    (mem_data)
   );

   // The pending transfer is withdrawn in the very cycle ERROR first appears.
   assign htrans    = ((state_q == FILL_BURST) && hresp) ? HTRANS_IDLE : htrans_q;
   assign haddr     = haddr_q;
   assign mem_ready = mem_ready_q;
   assign mem_err   = mem_err_q;
   assign hburst    = HBURST_INCR4;
   assign hsize     = HSIZE_WORD;
   assign hwrite    = 1'b0;

endmodule

// File: tb/tb_ahb_line_fill_ctrl.sv
// Scoreboard bench for ahb_line_fill_ctrl: stimulus queues expected bus
// transfers, line responses and per-cycle snapshots; a monitor checks them.
module tb_ahb_line_fill_ctrl;
   import ahb_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic [127:0] mem_data;
   logic         mem_ready, mem_err;
   logic [31:0]  haddr;
   logic [1:0]   htrans;
   logic [2:0]   hburst, hsize;
   logic         hwrite;
   logic [31:0]  hrdata;
   logic         hready, hresp;

   ahb_line_fill_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .mem_err   (mem_err),
      .haddr     (haddr),
      .htrans    (htrans),
      .hburst    (hburst),
      .hsize     (hsize),
      .hwrite    (hwrite),
      .hrdata    (hrdata),
      .hready    (hready),
      .hresp     (hresp)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; logic [127:0] data; logic err; bit chk_data; } resp_t;
   typedef struct { logic [31:0] addr; logic [1:0] trans; } xfer_t;
   typedef struct {
      int cyc; string name; logic [1:0] trans;
      bit chk_rdy; logic rdy; logic err;
      bit chk_data; logic [127:0] data;
      bit chk_addr; logic [31:0] addr;
   } point_t;

   resp_t  resp_q[$];
   xfer_t  xfer_q[$];
   point_t pt_q[$];

   int n_checks = 0;
   int n_errs   = 0;

   // Slave behaviour knobs, set by the stimulus before each fill.
   logic [31:0] beat_data[4];
   int stall_beat = -1;
   int stall_n    = 0;
   int err_beat   = -1;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic void add_pt(input int c, input string nm, input logic [1:0] tr,
                                  input bit chk_rdy, input logic rdy, input logic err,
                                  input bit chk_data, input logic [127:0] data,
                                  input bit chk_addr, input logic [31:0] addr);
      point_t p;
      p.cyc = c; p.name = nm; p.trans = tr;
      p.chk_rdy = chk_rdy; p.rdy = rdy; p.err = err;
      p.chk_data = chk_data; p.data = data;
      p.chk_addr = chk_addr; p.addr = addr;
      pt_q.push_back(p);
   endfunction

   function automatic void exp_xfer(input logic [31:0] a, input logic [1:0] t);
      xfer_t x;
      x.addr = a; x.trans = t;
      xfer_q.push_back(x);
   endfunction

   function automatic void exp_fill(input logic [31:0] base);
      exp_xfer(base, HTRANS_NONSEQ);
      exp_xfer(base + 32'h4, HTRANS_SEQ);
      exp_xfer(base + 32'h8, HTRANS_SEQ);
      exp_xfer(base + 32'hC, HTRANS_SEQ);
   endfunction

   function automatic void exp_resp(input int c, input logic [127:0] d, input logic e, input bit cd);
      resp_t r;
      r.cyc = c; r.data = d; r.err = e; r.chk_data = cd;
      resp_q.push_back(r);
   endfunction

   function automatic void set_beats(input logic [31:0] b0, input logic [31:0] b1,
                                     input logic [31:0] b2, input logic [31:0] b3);
      beat_data[0] = b0; beat_data[1] = b1; beat_data[2] = b2; beat_data[3] = b3;
   endfunction

   // AHB slave: drives hready/hresp/hrdata just after each rising edge.
   initial begin
      bit dp, err1;
      int dbeat, nbeat, waits;
      dp = 0; err1 = 0; dbeat = 0; nbeat = 0; waits = 0;
      hready = 1'b1; hresp = 1'b0; hrdata = '0;
      forever begin
         @(posedge clk); #1;
         if (dp) begin
            if (err1) begin
               hready = 1'b1; hresp = 1'b1; hrdata = 32'hEEEE_0000;
            end else if (dbeat == err_beat) begin
               hready = 1'b0; hresp = 1'b1; hrdata = 32'hEEEE_0000; err1 = 1;
            end else if (dbeat == stall_beat && waits < stall_n) begin
               hready = 1'b0; hresp = 1'b0; hrdata = 32'hBAD0_0000 | 32'(dbeat); waits++;
            end else begin
               hready = 1'b1; hresp = 1'b0; hrdata = beat_data[dbeat];
            end
         end else begin
            hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
         end
         @(negedge clk);
         if (rst) begin
            dp = 0; err1 = 0; waits = 0;
         end else begin
            if (dp && hready) begin
               dp = 0; err1 = 0;
            end
            if (hready && htrans != HTRANS_IDLE) begin
               dp    = 1;
               dbeat = (htrans == HTRANS_NONSEQ) ? 0 : nbeat;
               nbeat = (dbeat + 1) % 4;
               waits = 0;
            end
         end
      end
   end

   // Monitor: compares DUT outputs against the queued expectations.
   initial begin
      bit          prev_wait;
      logic [31:0] prev_addr;
      logic [1:0]  prev_trans;
      xfer_t       x;
      resp_t       r;
      point_t      p;
      prev_wait = 0; prev_addr = '0; prev_trans = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_wait = 0;
         end else begin
            if (hready && htrans != HTRANS_IDLE) begin
               if (xfer_q.size() == 0) begin
                  n_checks++; n_errs++;
                  $display("FAIL unexpected_xfer: got haddr=0x%0h htrans=%b expected none (cycle %0d)",
                           haddr, htrans, cyc);
               end else begin
                  x = xfer_q.pop_front();
                  chk("xfer_haddr", haddr, x.addr);
                  chk("xfer_htrans", htrans, x.trans);
                  chk("xfer_ctrl", {hburst, hsize, hwrite}, {HBURST_INCR4, HSIZE_WORD, 1'b0});
               end
            end
            if (prev_wait) begin
               chk("stall_hold_haddr", haddr, prev_addr);
               chk("stall_hold_htrans", htrans, prev_trans);
            end
            prev_wait  = !hready && !hresp && (htrans != HTRANS_IDLE);
            prev_addr  = haddr;
            prev_trans = htrans;

            if (mem_ready) begin
               if (resp_q.size() == 0) begin
                  n_checks++; n_errs++;
                  $display("FAIL spurious_ready: got mem_ready=1 expected 0 (cycle %0d)", cyc);
               end else begin
                  r = resp_q.pop_front();
                  chk("resp_cycle", cyc, r.cyc);
                  chk("resp_err", mem_err, r.err);
                  if (r.chk_data) chk("resp_data", mem_data, r.data);
               end
            end
            if (resp_q.size() != 0 && cyc > resp_q[0].cyc) begin
               n_checks++; n_errs++;
               $display("FAIL resp_timeout: got no mem_ready expected one at cycle %0d (cycle %0d)",
                        resp_q[0].cyc, cyc);
               void'(resp_q.pop_front());
            end

            for (int i = pt_q.size() - 1; i >= 0; i--) begin
               if (pt_q[i].cyc == cyc) begin
                  p = pt_q[i];
                  chk({p.name, "_htrans"}, htrans, p.trans);
                  if (p.chk_rdy) chk({p.name, "_ready_err"}, {mem_ready, mem_err}, {p.rdy, p.err});
                  if (p.chk_data) chk({p.name, "_data"}, mem_data, p.data);
                  if (p.chk_addr) chk({p.name, "_haddr"}, haddr, p.addr);
                  pt_q.delete(i);
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 60 && resp_q.size() != 0; i++) step();
      repeat (4) step();
   endtask

   // Directed stimulus.
   initial begin
      int t, t2;
      logic [127:0] l1, l2, l4, l6;
      rst = 1'b1; mem_req = 1'b0; mem_addr = '0;
      set_beats(32'h0, 32'h0, 32'h0, 32'h0);
      l1 = 128'h00000044_00000033_00000022_00000011;
      l2 = 128'h00000088_00000077_00000066_00000055;
      l4 = 128'h00000004_00000003_00000002_00000001;
      l6 = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;

      repeat (3) step();
      rst = 1'b0; t = cyc;
      add_pt(t, "reset", HTRANS_IDLE, 1, 1'b0, 1'b0, 1, 128'h0, 1, 32'h0);
      step(); step();

      // Zero-wait fill.
      set_beats(32'h11, 32'h22, 32'h33, 32'h44);
      t = cyc; mem_req = 1'b1; mem_addr = 32'h0000_1238;
      exp_fill(32'h1230);
      exp_resp(t + 6, l1, 1'b0, 1);
      add_pt(t + 1, "t1_nonseq", HTRANS_NONSEQ, 1, 1'b0, 1'b0, 0, '0, 1, 32'h1230);
      add_pt(t + 4, "t1_last_seq", HTRANS_SEQ, 0, 1'b0, 1'b0, 0, '0, 1, 32'h123C);
      add_pt(t + 5, "t1_idle", HTRANS_IDLE, 1, 1'b0, 1'b0, 0, '0, 0, '0);
      add_pt(t + 8, "t1_data_hold", HTRANS_IDLE, 1, 1'b0, 1'b0, 1, l1, 0, '0);
      step();
      mem_req = 1'b0; mem_addr = 32'hFFFF_FFFF;
      wait_done();

      // Two wait states on the beat-1 data phase.
      set_beats(32'h55, 32'h66, 32'h77, 32'h88);
      stall_beat = 1; stall_n = 2;
      t = cyc; mem_req = 1'b1; mem_addr = 32'h0000_1238;
      exp_fill(32'h1230);
      exp_resp(t + 8, l2, 1'b0, 1);
      add_pt(t + 3, "t2_stall0", HTRANS_SEQ, 0, 1'b0, 1'b0, 0, '0, 1, 32'h1238);
      add_pt(t + 4, "t2_stall1", HTRANS_SEQ, 0, 1'b0, 1'b0, 0, '0, 1, 32'h1238);
      add_pt(t + 7, "t2_idle", HTRANS_IDLE, 1, 1'b0, 1'b0, 0, '0, 0, '0);
      step();
      mem_req = 1'b0;
      wait_done();
      stall_beat = -1; stall_n = 0;

      // ERROR response on beat 2.
      set_beats(32'h99, 32'hAA, 32'hBB, 32'hCC);
      err_beat = 2;
      t = cyc; mem_req = 1'b1; mem_addr = 32'h0000_1238;
      exp_xfer(32'h1230, HTRANS_NONSEQ);
      exp_xfer(32'h1234, HTRANS_SEQ);
      exp_xfer(32'h1238, HTRANS_SEQ);
      exp_resp(t + 6, '0, 1'b1, 0);
      add_pt(t + 4, "t3_err_first", HTRANS_IDLE, 1, 1'b0, 1'b0, 0, '0, 0, '0);
      add_pt(t + 5, "t3_err_second", HTRANS_IDLE, 1, 1'b0, 1'b0, 0, '0, 0, '0);
      add_pt(t + 6, "t3_done", HTRANS_IDLE, 1, 1'b1, 1'b1, 0, '0, 0, '0);
      add_pt(t + 7, "t3_after", HTRANS_IDLE, 1, 1'b0, 1'b0, 0, '0, 0, '0);
      step();
      mem_req = 1'b0;
      wait_done();
      err_beat = -1;

      // Request held through DONE, dropped before IDLE samples it.
      set_beats(32'h1, 32'h2, 32'h3, 32'h4);
      t = cyc; mem_req = 1'b1; mem_addr = 32'h0000_ABCF;
      exp_fill(32'hABC0);
      exp_resp(t + 6, l4, 1'b0, 1);
      add_pt(t + 6, "t4_done", HTRANS_IDLE, 1, 1'b1, 1'b0, 0, '0, 0, '0);
      add_pt(t + 7, "t4_idle0", HTRANS_IDLE, 1, 1'b0, 1'b0, 0, '0, 0, '0);
      add_pt(t + 8, "t4_idle1", HTRANS_IDLE, 0, 1'b0, 1'b0, 0, '0, 0, '0);
      add_pt(t + 9, "t4_idle2", HTRANS_IDLE, 0, 1'b0, 1'b0, 0, '0, 0, '0);
      repeat (7) step();
      mem_req = 1'b0;
      wait_done();

      // Request held into IDLE: back-to-back fills 7 cycles apart.
      t = cyc; mem_req = 1'b1; mem_addr = 32'h0000_ABCF;
      exp_fill(32'hABC0);
      exp_fill(32'hABC0);
      exp_resp(t + 6, l4, 1'b0, 1);
      exp_resp(t + 13, l4, 1'b0, 1);
      add_pt(t + 6, "t5_done", HTRANS_IDLE, 1, 1'b1, 1'b0, 0, '0, 0, '0);
      add_pt(t + 7, "t5_idle", HTRANS_IDLE, 1, 1'b0, 1'b0, 0, '0, 0, '0);
      add_pt(t + 8, "t5_nonseq", HTRANS_NONSEQ, 0, 1'b0, 1'b0, 0, '0, 1, 32'hABC0);
      repeat (8) step();
      mem_req = 1'b0;
      wait_done();

      // Reset while in BURST with address counter at 2, then a fresh fill.
      set_beats(32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003, 32'h5A5A_0004);
      t = cyc; mem_req = 1'b1; mem_addr = 32'h0000_3000;
      exp_xfer(32'h3000, HTRANS_NONSEQ);
      exp_xfer(32'h3004, HTRANS_SEQ);
      add_pt(t + 4, "t6_post_reset", HTRANS_IDLE, 1, 1'b0, 1'b0, 1, 128'h0, 1, 32'h0);
      step();
      mem_req = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      set_beats(32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
      t2 = cyc; mem_req = 1'b1; mem_addr = 32'h0000_2004;
      exp_fill(32'h2000);
      exp_resp(t2 + 6, l6, 1'b0, 1);
      step();
      mem_req = 1'b0;
      wait_done();

      chk("xfer_queue_drained", 32'(xfer_q.size()), 32'h0);
      chk("resp_queue_drained", 32'(resp_q.size()), 32'h0);
      chk("point_queue_drained", 32'(pt_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
